pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
Parametrised hazard and pipeline-control unit for the 5-stage RV32 pipeline. It replaces the forwarding-only block. It adds:
- load-use stalls and branch flushes;
- a stall sequencer for a multicycle execute unit with configurable latency;
- saturating stall and flush event counters for performance measurement.

It sits beside pipeline_top's stage modules and drives their stall and flush enables plus the execute-stage forwarding muxes.

Parameters:
REG_AW, 5, register address width
MUL_LAT, 4, execute-stage cycles for a multicycle op (>=1)
CNT_W, 16, width of the performance counters
FWD_EN, 1, 1 enables forwarding; 0 forces ForwardAE/BE to 00 and stalls on any RAW hazard to E/M/W

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
Rs1_D, Rs2_D  in  REG_AW  source registers in decode
Rs1_E, Rs2_E  in  REG_AW  source registers in execute
RD_E, RD_M, RD_W  in  REG_AW  destination registers per stage
RegWriteE, RegWriteM, RegWriteW  in  1  write enables per stage
LoadE  in  1  instruction in execute is a load (ResultSrcE selects memory)
PCSrcE  in  1  taken branch/jump resolved in execute
MulStartE  in  1  multicycle op present in execute
ClrCnt  in  1  synchronous clear of performance counters
StallF, StallD, StallE  out  1  hold the PC, IF/ID and ID/EX registers
FlushD, FlushE  out  1  bubble the IF/ID and ID/EX registers
ForwardAE, ForwardBE  out  2  00 regfile, 10 from M, 01 from W
MulBusy  out  1  multicycle op in progress
MulDoneE  out  1  one-cycle pulse, last execute cycle of a multicycle op
StallCnt, FlushCnt  out  CNT_W  saturating event counters

Behaviour:
- Reset (rst=1 at clk edge):
  - FSM goes to IDLE; cycle counter and both performance counters go to 0.
  - During rst all stall/flush outputs are 0, MulBusy=0 and MulDoneE=0.
  - Reset mid-BUSY abandons the op; no MulDoneE pulse is produced.
- Forwarding (combinational):
  - ForwardAE=10 if RegWriteM & RD_M!=0 & RD_M==Rs1_E.
  - Else ForwardAE=01 if RegWriteW & RD_W!=0 & RD_W==Rs1_E.
  - Else ForwardAE=00.
  - M has priority over W. ForwardBE is the same rule using Rs2_E.
- Load-use (combinational): lwStall = LoadE & RD_E!=0 & (RD_E==Rs1_D | RD_E==Rs2_D).
- FWD_EN=0: rawStall = any of E/M/W writing a nonzero register equal to Rs1_D or Rs2_D. It replaces lwStall.
- Multicycle FSM, states IDLE and BUSY, counter width clog2(MUL_LAT)+1:
  - IDLE & MulStartE & MUL_LAT>1: go to BUSY, cnt=MUL_LAT-2.
  - BUSY & cnt!=0: cnt decrements.
  - BUSY & cnt==0: return to IDLE.
  - MulBusy = (IDLE & MulStartE & MUL_LAT>1) | BUSY.
  - MulDoneE = (BUSY & cnt==0) | (IDLE & MulStartE & MUL_LAT==1).
  - mulStall = MulBusy & ~MulDoneE.
- Outputs:
  - StallF = StallD = lwStall | mulStall.
  - StallE = mulStall.
  - FlushD = PCSrcE & ~mulStall.
  - FlushE = (lwStall | PCSrcE) & ~mulStall.
  - An op held in E by StallE is never flushed. A pending PCSrcE takes effect in the MulDoneE cycle.
- Simultaneous lwStall & PCSrcE: flush wins for D; E still gets a bubble. StallF/StallD stay asserted, which is harmless because FlushD clears D.
- MulStartE while already BUSY is ignored; the same op is still in E.
- Counters:
  - StallCnt += 1 in each cycle StallF=1.
  - FlushCnt += 1 in each cycle FlushD=1.
  - Both saturate at 2^CNT_W-1.
  - ClrCnt forces both to 0 and takes priority over increment.
- Latency: all control outputs are combinational from inputs and current state. Only FSM and counter state is registered (1-cycle update).

Decomposition:
- Shared package pipe_pkg holds:
  - typedef fwd_sel_t (2-bit enum FWD_REG=00, FWD_WB=01, FWD_MEM=10);
  - typedef mul_state_t (IDLE, BUSY);
  - constant REG_ZERO.
- One natural sub-module: sat_counter (parametrised CNT_W, inc, clr), instantiated twice.

Test Plan:
1. Back-to-back `add x5` then `add x6,x5,x1`, with RD_M=5, RegWriteM=1, Rs1_E=5 -> ForwardAE=10, no stall. Same case with RD_M=0 -> ForwardAE=00.
2. RD_M=RD_W=7, both writing, Rs2_E=7 -> ForwardBE=10 (M priority). Drop RegWriteM -> 01.
3. Load-use: LoadE=1, RD_E=3, Rs1_D=3 -> StallF=StallD=FlushE=1 for exactly 1 cycle, StallCnt=1.
4. MUL_LAT=4, MulStartE held with PCSrcE=1 -> StallF/D/E=1 for 3 cycles, MulDoneE in cycle 4. FlushD=FlushE=1 only in cycle 4.
5. Assert rst during BUSY cycle 2 -> next cycle MulBusy=0, all stalls 0, counters 0, no MulDoneE.
6. CNT_W=2: hold lwStall for 5 cycles -> StallCnt saturates at 3. ClrCnt together with StallF=1 -> StallCnt=0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and constants for the RV32 pipeline control blocks.
package pipe_pkg;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mul_state_t;

  localparam int unsigned REG_ZERO = 0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc && (cnt != CNT_MAX)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/pipeline control for the 5-stage RV32 pipeline: forwarding, load-use
// and RAW stalls, branch flushes, multicycle execute sequencing, event counters.
module pipeline_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned MUL_LAT = 4,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned FWD_EN  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] Rs1_D,
  input  logic [REG_AW-1:0] Rs2_D,
  input  logic [REG_AW-1:0] Rs1_E,
  input  logic [REG_AW-1:0] Rs2_E,
  input  logic [REG_AW-1:0] RD_E,
  input  logic [REG_AW-1:0] RD_M,
  input  logic [REG_AW-1:0] RD_W,
  input  logic              RegWriteE,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic              LoadE,
  input  logic              PCSrcE,
  input  logic              MulStartE,
  input  logic              ClrCnt,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              FlushD,
  output logic              FlushE,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              MulBusy,
  output logic              MulDoneE,
  output logic [CNT_W-1:0]  StallCnt,
  output logic [CNT_W-1:0]  FlushCnt
);

  localparam logic [REG_AW-1:0] ZR       = REG_AW'(REG_ZERO);
  localparam int unsigned       CW       = $clog2(MUL_LAT) + 1;
  localparam bit                MULTI    = (MUL_LAT > 1);
  localparam logic [CW-1:0]     CNT_INIT = MULTI ? CW'(MUL_LAT - 2) : '0;

  logic e_wr, m_wr, w_wr;
  logic hit_e, hit_m, hit_w;
  logic lw_stall, raw_stall, d_stall;

  assign e_wr  = RegWriteE && (RD_E != ZR);
  assign m_wr  = RegWriteM && (RD_M != ZR);
  assign w_wr  = RegWriteW && (RD_W != ZR);
  assign hit_e = (RD_E == Rs1_D) || (RD_E == Rs2_D);
  assign hit_m = (RD_M == Rs1_D) || (RD_M == Rs2_D);
  assign hit_w = (RD_W == Rs1_D) || (RD_W == Rs2_D);

  assign lw_stall  = LoadE && (RD_E != ZR) && hit_e;
  assign raw_stall = (e_wr && hit_e) || (m_wr && hit_m) || (w_wr && hit_w);
  assign d_stall   = (FWD_EN != 0) ? lw_stall : raw_stall;

  always_comb begin
    ForwardAE = FWD_REG;
    ForwardBE = FWD_REG;
    if (FWD_EN != 0) begin
      if (m_wr && (RD_M == Rs1_E))      ForwardAE = FWD_MEM;
      else if (w_wr && (RD_W == Rs1_E)) ForwardAE = FWD_WB;
      if (m_wr && (RD_M == Rs2_E))      ForwardBE = FWD_MEM;
      else if (w_wr && (RD_W == Rs2_E)) ForwardBE = FWD_WB;
    end
  end

  mul_state_t    state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          busy, done, mul_stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // A single-cycle op (MUL_LAT==1) never leaves IDLE; it completes in place.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: begin
        if (MulStartE) begin
          if (MULTI) begin
            busy     = 1'b1;
            state_nx = BUSY;
            cnt_nx   = CNT_INIT;
          end else begin
            done = 1'b1;
          end
        end
      end
      BUSY: begin
        busy = 1'b1;
        if (cnt == '0) begin
          done     = 1'b1;
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt - CW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign mul_stall = busy && !done;

  assign StallF   = !rst && (d_stall || mul_stall);
  assign StallD   = StallF;
  assign StallE   = !rst && mul_stall;
  assign FlushD   = !rst && PCSrcE && !mul_stall;
  assign FlushE   = !rst && (d_stall || PCSrcE) && !mul_stall;
  assign MulBusy  = !rst && busy;
  assign MulDoneE = !rst && done;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (StallF),
    .clr (ClrCnt),
    .cnt (StallCnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .inc (FlushD),
    .clr (ClrCnt),
    .cnt (FlushCnt)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: combinational vector table plus
// multicycle, reset, saturation and no-forwarding sequences.
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] Rs1_D, Rs2_D, Rs1_E, Rs2_E, RD_E, RD_M, RD_W;
  logic       RegWriteE, RegWriteM, RegWriteW, LoadE, PCSrcE, MulStartE, ClrCnt;

  logic       StallF, StallD, StallE, FlushD, FlushE, MulBusy, MulDoneE;
  logic [1:0] ForwardAE, ForwardBE;
  logic [1:0] StallCnt, FlushCnt;

  logic       StallF_nf, StallD_nf, StallE_nf, FlushD_nf, FlushE_nf, MulBusy_nf, MulDoneE_nf;
  logic [1:0] ForwardAE_nf, ForwardBE_nf;
  logic [7:0] StallCnt_nf, FlushCnt_nf;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.REG_AW(5), .MUL_LAT(4), .CNT_W(2), .FWD_EN(1)) dut (
    .clk(clk), .rst(rst),
    .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .Rs1_E(Rs1_E), .Rs2_E(Rs2_E),
    .RD_E(RD_E), .RD_M(RD_M), .RD_W(RD_W),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .LoadE(LoadE), .PCSrcE(PCSrcE), .MulStartE(MulStartE), .ClrCnt(ClrCnt),
    .StallF(StallF), .StallD(StallD), .StallE(StallE),
    .FlushD(FlushD), .FlushE(FlushE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .MulBusy(MulBusy), .MulDoneE(MulDoneE),
    .StallCnt(StallCnt), .FlushCnt(FlushCnt)
  );

  pipeline_hazard_ctrl #(.REG_AW(5), .MUL_LAT(1), .CNT_W(8), .FWD_EN(0)) dut_nf (
    .clk(clk), .rst(rst),
    .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .Rs1_E(Rs1_E), .Rs2_E(Rs2_E),
    .RD_E(RD_E), .RD_M(RD_M), .RD_W(RD_W),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .LoadE(LoadE), .PCSrcE(PCSrcE), .MulStartE(MulStartE), .ClrCnt(ClrCnt),
    .StallF(StallF_nf), .StallD(StallD_nf), .StallE(StallE_nf),
    .FlushD(FlushD_nf), .FlushE(FlushE_nf),
    .ForwardAE(ForwardAE_nf), .ForwardBE(ForwardBE_nf),
    .MulBusy(MulBusy_nf), .MulDoneE(MulDoneE_nf),
    .StallCnt(StallCnt_nf), .FlushCnt(FlushCnt_nf)
  );

  typedef struct {
    string      name;
    logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic       we_e, we_m, we_w, load_e, pcsrc;
    logic [1:0] fa, fb;
    logic       stall_f, stall_e, flush_d, flush_e;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string nm,
      logic [4:0] rs1_d, logic [4:0] rs2_d, logic [4:0] rs1_e, logic [4:0] rs2_e,
      logic [4:0] rd_e, logic [4:0] rd_m, logic [4:0] rd_w,
      logic we_e, logic we_m, logic we_w, logic load_e, logic pcsrc,
      logic [1:0] fa, logic [1:0] fb,
      logic stall_f, logic stall_e, logic flush_d, logic flush_e);
    vec_t v;
    v.name = nm;
    v.rs1_d = rs1_d; v.rs2_d = rs2_d; v.rs1_e = rs1_e; v.rs2_e = rs2_e;
    v.rd_e = rd_e; v.rd_m = rd_m; v.rd_w = rd_w;
    v.we_e = we_e; v.we_m = we_m; v.we_w = we_w; v.load_e = load_e; v.pcsrc = pcsrc;
    v.fa = fa; v.fb = fb;
    v.stall_f = stall_f; v.stall_e = stall_e; v.flush_d = flush_d; v.flush_e = flush_e;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_idle();
    Rs1_D = '0; Rs2_D = '0; Rs1_E = '0; Rs2_E = '0;
    RD_E = '0; RD_M = '0; RD_W = '0;
    RegWriteE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0;
    LoadE = 1'b0; PCSrcE = 1'b0; MulStartE = 1'b0; ClrCnt = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_counters();
    step();
    set_idle();
    ClrCnt = 1'b1;
    @(negedge clk);
    step();
    ClrCnt = 1'b0;
  endtask

  initial begin
    //     name      rs1d rs2d rs1e rs2e rde rdm rdw weE weM weW ld  br   fa     fb     sF sE fD fE
    vecs.push_back(mk("fwdA_mem",  1, 2, 5, 1, 0, 5, 0, 0, 1, 0, 0, 0, 2'b10, 2'b00, 0, 0, 0, 0));
    vecs.push_back(mk("fwdA_x0",   1, 2, 5, 1, 0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0));
    vecs.push_back(mk("fwdB_prio", 1, 2, 1, 7, 0, 7, 7, 0, 1, 1, 0, 0, 2'b00, 2'b10, 0, 0, 0, 0));
    vecs.push_back(mk("fwdB_wb",   1, 2, 1, 7, 0, 7, 7, 0, 0, 1, 0, 0, 2'b00, 2'b01, 0, 0, 0, 0));
    vecs.push_back(mk("fwdAB_wb",  1, 2, 7, 7, 0, 7, 7, 0, 0, 1, 0, 0, 2'b01, 2'b01, 0, 0, 0, 0));
    vecs.push_back(mk("fwd_wb_x0", 1, 2, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0));
    vecs.push_back(mk("fwd_split", 1, 2, 4, 9, 0, 4, 9, 0, 1, 1, 0, 0, 2'b10, 2'b01, 0, 0, 0, 0));
    vecs.push_back(mk("lw_rs1",    3, 2, 1, 1, 3, 0, 0, 1, 0, 0, 1, 0, 2'b00, 2'b00, 1, 0, 0, 1));
    vecs.push_back(mk("lw_rs2",    1, 3, 1, 1, 3, 0, 0, 1, 0, 0, 1, 0, 2'b00, 2'b00, 1, 0, 0, 1));
    vecs.push_back(mk("lw_x0",     0, 0, 1, 1, 0, 0, 0, 1, 0, 0, 1, 0, 2'b00, 2'b00, 0, 0, 0, 0));
    vecs.push_back(mk("alu_raw",   3, 2, 1, 1, 3, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0));
    vecs.push_back(mk("branch",    1, 2, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0, 0, 1, 1));
    vecs.push_back(mk("lw_branch", 3, 2, 1, 1, 3, 0, 0, 1, 0, 0, 1, 1, 2'b00, 2'b00, 1, 0, 1, 1));
    vecs.push_back(mk("quiet",     1, 2, 3, 4, 5, 6, 8, 1, 1, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0));

    // Reset: outputs held quiet even with every hazard source asserted.
    set_idle();
    rst = 1'b1;
    LoadE = 1'b1; RD_E = 5'd3; Rs1_D = 5'd3; PCSrcE = 1'b1; MulStartE = 1'b1;
    @(negedge clk);
    chk("rst_stallF", StallF, 0);
    chk("rst_stallE", StallE, 0);
    chk("rst_flushD", FlushD, 0);
    chk("rst_flushE", FlushE, 0);
    chk("rst_busy",   MulBusy, 0);
    chk("rst_done",   MulDoneE, 0);
    step();
    rst = 1'b0;
    set_idle();
    @(negedge clk);
    chk("rst_stallcnt", StallCnt, 0);
    chk("rst_flushcnt", FlushCnt, 0);
    chk("rst_busy2",    MulBusy, 0);

    foreach (vecs[i]) begin
      step();
      set_idle();
      Rs1_D = vecs[i].rs1_d; Rs2_D = vecs[i].rs2_d;
      Rs1_E = vecs[i].rs1_e; Rs2_E = vecs[i].rs2_e;
      RD_E = vecs[i].rd_e; RD_M = vecs[i].rd_m; RD_W = vecs[i].rd_w;
      RegWriteE = vecs[i].we_e; RegWriteM = vecs[i].we_m; RegWriteW = vecs[i].we_w;
      LoadE = vecs[i].load_e; PCSrcE = vecs[i].pcsrc;
      @(negedge clk);
      chk({vecs[i].name, ".fa"}, ForwardAE, vecs[i].fa);
      chk({vecs[i].name, ".fb"}, ForwardBE, vecs[i].fb);
      chk({vecs[i].name, ".stallF"}, StallF, vecs[i].stall_f);
      chk({vecs[i].name, ".stallD"}, StallD, vecs[i].stall_f);
      chk({vecs[i].name, ".stallE"}, StallE, vecs[i].stall_e);
      chk({vecs[i].name, ".flushD"}, FlushD, vecs[i].flush_d);
      chk({vecs[i].name, ".flushE"}, FlushE, vecs[i].flush_e);
    end

    // Single-cycle load-use stall is counted once.
    clear_counters();
    LoadE = 1'b1; RD_E = 5'd3; Rs1_D = 5'd3;
    @(negedge clk);
    chk("lu_stallF", StallF, 1);
    chk("lu_flushE", FlushE, 1);
    chk("lu_cnt0",   StallCnt, 0);
    step();
    set_idle();
    @(negedge clk);
    chk("lu_stallF_off", StallF, 0);
    chk("lu_stallcnt",   StallCnt, 1);
    chk("lu_flushcnt",   FlushCnt, 0);

    // Multicycle op (4 cycles) with a pending taken branch.
    clear_counters();
    MulStartE = 1'b1; PCSrcE = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      if (c > 1) step();
      @(negedge clk);
      chk($sformatf("mul_c%0d_stallF", c), StallF, (c < 4));
      chk($sformatf("mul_c%0d_stallE", c), StallE, (c < 4));
      chk($sformatf("mul_c%0d_flushD", c), FlushD, (c == 4));
      chk($sformatf("mul_c%0d_flushE", c), FlushE, (c == 4));
      chk($sformatf("mul_c%0d_done",   c), MulDoneE, (c == 4));
      chk($sformatf("mul_c%0d_busy",   c), MulBusy, 1);
    end
    step();
    set_idle();
    @(negedge clk);
    chk("mul_after_busy", MulBusy, 0);
    chk("mul_stallcnt",   StallCnt, 3);
    chk("mul_flushcnt",   FlushCnt, 1);

    // Reset in the second BUSY cycle abandons the op.
    clear_counters();
    MulStartE = 1'b1;
    @(negedge clk);
    chk("mrst_busy_c1", MulBusy, 1);
    step();
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_stallF", StallF, 0);
    chk("mrst_stallE", StallE, 0);
    chk("mrst_busy",   MulBusy, 0);
    chk("mrst_done",   MulDoneE, 0);
    step();
    rst = 1'b0;
    MulStartE = 1'b0;
    @(negedge clk);
    chk("mrst_post_busy",   MulBusy, 0);
    chk("mrst_post_stallE", StallE, 0);
    chk("mrst_post_cnt",    StallCnt, 0);
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("mrst_nodone%0d", c), MulDoneE, 0);
      step();
      @(negedge clk);
    end

    // Stall counter saturation and clear-over-increment.
    clear_counters();
    LoadE = 1'b1; RD_E = 5'd3; Rs2_D = 5'd3;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) step();
      @(negedge clk);
      chk($sformatf("sat_cnt%0d", i), StallCnt, (i < 3) ? i : 3);
    end
    step();
    ClrCnt = 1'b1;
    @(negedge clk);
    chk("sat_stallF",  StallF, 1);
    chk("sat_cnt_max", StallCnt, 3);
    step();
    set_idle();
    @(negedge clk);
    chk("sat_cleared", StallCnt, 0);

    // No-forwarding build: every RAW to E/M/W stalls decode.
    step();
    set_idle();
    RegWriteM = 1'b1; RD_M = 5'd4; Rs1_D = 5'd4; Rs1_E = 5'd4;
    @(negedge clk);
    chk("nf_m_stallF", StallF_nf, 1);
    chk("nf_m_flushE", FlushE_nf, 1);
    chk("nf_m_fwdA",   ForwardAE_nf, 0);
    chk("fw_m_fwdA",   ForwardAE, 2);
    chk("fw_m_stallF", StallF, 0);
    step();
    set_idle();
    RegWriteW = 1'b1; RD_W = 5'd9; Rs2_D = 5'd9;
    @(negedge clk);
    chk("nf_w_stallD", StallD_nf, 1);
    step();
    RD_W = 5'd0; Rs2_D = 5'd0;
    @(negedge clk);
    chk("nf_x0_stallD", StallD_nf, 0);
    step();
    set_idle();
    RegWriteE = 1'b1; RD_E = 5'd6; Rs1_D = 5'd6;
    @(negedge clk);
    chk("nf_e_stallF", StallF_nf, 1);
    chk("fw_e_stallF", StallF, 0);
    step();
    set_idle();
    MulStartE = 1'b1;
    @(negedge clk);
    chk("nf_mul1_done",   MulDoneE_nf, 1);
    chk("nf_mul1_busy",   MulBusy_nf, 0);
    chk("nf_mul1_stallE", StallE_nf, 0);
    step();
    set_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
